vector_range_collector: RTL
===========================

// Module: vector_range_collector
// PURPOSE
// - Receive side of the vector range-check path: accepts a serial element stream over valid/ready.
// - Assembles ELEMS elements into one parallel vector.
// - Checks each element against lower/upper bounds as it arrives.
// - Presents vector_out, per-element error_pos, error_count and error_any under an out_valid/out_ready handshake.
// - Sits between a byte-serial source and the parallel vector consumers.
// PARAMETERS
// - ELEMS  12  elements per vector (>=2)
// - WIDTH  8   bits per element; bounds share this width
// - CNT_W  4   width of element index/count; must satisfy 2**CNT_W > ELEMS
// PORTS
// - clock        in   1            rising-edge clock
// - reset        in   1            asynchronous, active-high reset
// - in_data      in   WIDTH        incoming element
// - in_valid     in   1            in_data valid
// - in_ready     out  1            collector can accept an element
// - lower_bnd    in   WIDTH        inclusive lower bound, unsigned
// - upper_bnd    in   WIDTH        inclusive upper bound, unsigned
// - vector_out   out  ELEMS*WIDTH  element i at [i*WIDTH +: WIDTH]
// - error_pos    out  ELEMS        bit i = element i out of range
// - error_count  out  CNT_W        number of set bits in error_pos
// - error_any    out  1            |error_pos
// - out_valid    out  1            assembled vector available
// - out_ready    in   1            consumer takes vector
// BEHAVIOUR
// - Reset (async, immediate): state=COLLECT, idx=0, vector_out=0, error_pos=0, error_count=0,
//   error_any=0, out_valid=0, in_ready=1.
// - States: COLLECT, DONE.
// - COLLECT: in_ready=1. Element accept = in_valid&&in_ready.
//   - On accept: store in_data at slot idx.
//   - On accept: error_pos[idx] = (in_data<lower_bnd)||(in_data>upper_bnd), using bounds sampled that cycle.
//   - On accept: error_count += that bit; idx++.
//   - Accept with idx==ELEMS-1: idx<=0, go DONE.
// - DONE: in_ready=0, out_valid=1.
//   - out_valid && out_ready: next cycle COLLECT with in_ready=1.
//   - Also on that handshake: error_pos and error_count cleared; vector_out holds until overwritten.
// - Latency: last element accepted at edge t -> out_valid=1 after edge t. One vector per ELEMS+1 cycles at best.
// - Outputs vector_out/error_pos/error_count/error_any are stable throughout DONE.
// - error_any is combinational OR of error_pos.
// - Boundaries:
//   - Element == bound -> in range.
//   - lower_bnd > upper_bnd -> every element flagged.
//   - in_valid low mid-vector -> idx holds; no timeout.
//   - out_ready high in COLLECT -> ignored.
//   - Reset mid-vector -> partial vector discarded, restart at slot 0.
//   - error_count max = ELEMS; no wrap, given the CNT_W constraint.
// CONFIGURATION
// - Macro VECTOR_RANGE_CLAMP_EN.
// - Defined: out-of-range element is stored clamped.
//   - Below lower_bnd -> lower_bnd.
//   - Above upper_bnd -> upper_bnd.
//   - If lower>upper, stored as lower_bnd.
//   - error_pos/error_count still report the original violation.
// - Undefined: raw in_data stored unchanged.
// TESTING (ELEMS=12, WIDTH=8)
// 1. Reset mid-vector after 5 elements -> out_valid=0, in_ready=1.
//    Then 12 elements 0x60, bounds 0x56..0xD5 -> error_pos=0x000, error_count=0.
// 2. Bounds 0x56..0xD5, elems[0..7,9,10]=0x55, [8]=0xD4, [11]=0x57 -> error_pos=0x6FF,
//    error_count=10, error_any=1, out_valid one cycle after 12th accept.
//    With VECTOR_RANGE_CLAMP_EN, the 0x55 slots read 0x56.
// 3. Elements equal to 0x56 and 0xD5, plus 0xD6 at slot 3 -> only error_pos[3]=1, error_count=1.
//    With VECTOR_RANGE_CLAMP_EN, slot 3 reads 0xD5.
// 4. out_ready held low 20 cycles after vector done -> in_ready=0, outputs stable, in_valid ignored.
//    out_ready pulse -> next cycle in_ready=1, error_pos=0.
// 5. Bounds 0x80..0x10 (inverted), any 12 elements -> error_pos=0xFFF, error_count=12.
// 6. in_valid random 50% gaps -> assembled vector matches send order; slot i = i-th accepted element.

Source files
------------

// File: rtl/vector_range_collector.sv
// Serial-to-parallel vector collector with per-element unsigned range check.
// Optional macro VECTOR_RANGE_CLAMP_EN stores out-of-range elements clamped to the bounds.
module vector_range_collector #(
  parameter int ELEMS = 12,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       lower_bnd,
  input  logic [WIDTH-1:0]       upper_bnd,
  output logic [ELEMS*WIDTH-1:0] vector_out,
  output logic [ELEMS-1:0]       error_pos,
  output logic [CNT_W-1:0]       error_count,
  output logic                   error_any,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [ELEMS*WIDTH-1:0] vector_q, vector_d;
  logic [ELEMS-1:0]       error_pos_q, error_pos_d;
  logic [CNT_W-1:0]       error_count_q, error_count_d;
  logic                   elem_err;
  logic [WIDTH-1:0]       store_val;

  always_comb begin
    elem_err = (in_data < lower_bnd) || (in_data > upper_bnd);
`ifdef VECTOR_RANGE_CLAMP_EN
    // Inverted bounds fall into the first branch so such elements store lower_bnd.
    if (lower_bnd > upper_bnd || in_data < lower_bnd) begin
      store_val = lower_bnd;
    end else if (in_data > upper_bnd) begin
      store_val = upper_bnd;
    end else begin
      store_val = in_data;
    end
`else
    store_val = in_data;
`endif
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    vector_d      = vector_q;
    error_pos_d   = error_pos_q;
    error_count_d = error_count_q;
    if (state_q == COLLECT) begin
      if (in_valid) begin
        for (int unsigned i = 0; i < ELEMS; i++) begin
          if (idx_q == CNT_W'(i)) begin
            vector_d[i*WIDTH +: WIDTH] = store_val;
            error_pos_d[i]             = elem_err;
          end
        end
        error_count_d = error_count_q + CNT_W'(elem_err);
        if (idx_q == CNT_W'(ELEMS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
    end else begin
      // Flags are cleared on release; the vector data is left to be overwritten.
      if (out_ready) begin
        state_d       = COLLECT;
        error_pos_d   = '0;
        error_count_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      vector_q      <= '0;
      error_pos_q   <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      vector_q      <= vector_d;
      error_pos_q   <= error_pos_d;
      error_count_q <= error_count_d;
    end
  end

  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == DONE);
  assign vector_out  = vector_q;
  assign error_pos   = error_pos_q;
  assign error_count = error_count_q;
  assign error_any   = |error_pos_q;

endmodule
